// File: rtl/nios_onchip_memory_dp_if.sv
// Avalon-MM slave port bundle for one side of the dual-port on-chip memory.
// A slave accepts an access when chipselect & (read | write); it never asserts waitrequest.
interface nios_onchip_memory_dp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
);
  logic [ADDR_WIDTH-1:0]   address;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/nios_onchip_memory_dp.sv
// True dual-port on-chip RAM with two Avalon-MM slave ports, byte enables and 1 or 2 cycle reads.
// Optional per-byte even parity with sticky error flags is enabled by defining NIOS_OCM_PARITY_EN.
module nios_onchip_memory_dp #(
  parameter int    DATA_WIDTH   = 32,
  parameter int    ADDR_WIDTH   = 11,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = "onchip_mem.hex"
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   reset_req,
  input  logic                   parity_inject,
  output logic [1:0]             parity_err,
  nios_onchip_memory_dp_if.slave s1,
  nios_onchip_memory_dp_if.slave s2
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // The memory image named by INIT_FILE is applied by the device programming flow, not by this logic.
  localparam string unusedInitFile = INIT_FILE;

  logic [ADDR_WIDTH-1:0] w_addr  [2];
  logic [NB-1:0]         w_be    [2];
  logic [DATA_WIDTH-1:0] w_wdata [2];
  logic [1:0]            w_wrEn;
  logic [1:0]            w_rdEn;
  logic [1:0]            w_rdValid;
  logic [DATA_WIDTH-1:0] w_rdData [2];

  assign w_addr[0]  = s1.address;
  assign w_addr[1]  = s2.address;
  assign w_be[0]    = s1.byteenable;
  assign w_be[1]    = s2.byteenable;
  assign w_wdata[0] = s1.writedata;
  assign w_wdata[1] = s2.writedata;

  // A simultaneous read+write is a write only.
  assign w_wrEn[0] = s1.chipselect & s1.write & ~reset_req;
  assign w_wrEn[1] = s2.chipselect & s2.write & ~reset_req;
  assign w_rdEn[0] = s1.chipselect & s1.read & ~s1.write & ~reset_req;
  assign w_rdEn[1] = s2.chipselect & s2.read & ~s2.write & ~reset_req;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // s2 is written first so that s1 wins on lanes both ports enable at the same address.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      for (int b = 0; b < NB; b++) begin
        if (w_wrEn[1] && w_be[1][b]) r_mem[w_addr[1]][8*b +: 8] <= w_wdata[1][8*b +: 8];
        if (w_wrEn[0] && w_be[0][b]) r_mem[w_addr[0]][8*b +: 8] <= w_wdata[0][8*b +: 8];
      end
    end
  end

`ifdef NIOS_OCM_PARITY_EN
  function automatic logic [NB-1:0] bytePar(input logic [DATA_WIDTH-1:0] d);
    logic [NB-1:0] par;
    par = '0;
    for (int b = 0; b < NB; b++) par[b] = ^d[8*b +: 8];
    return par;
  endfunction

  logic [NB-1:0] r_par [DEPTH];
  logic [NB-1:0] w_rdPar [2];
  logic [1:0]    w_parMiss;
  logic [1:0]    r_parErr;

  always_ff @(posedge clk) begin
    if (reset_n) begin
      for (int b = 0; b < NB; b++) begin
        if (w_wrEn[1] && w_be[1][b]) r_par[w_addr[1]][b] <= (^w_wdata[1][8*b +: 8]) ^ parity_inject;
        if (w_wrEn[0] && w_be[0][b]) r_par[w_addr[0]][b] <= (^w_wdata[0][8*b +: 8]) ^ parity_inject;
      end
    end
  end
`else
  logic w_unusedInject;
  assign w_unusedInject = parity_inject;
`endif

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic                  r_s0Valid;
    logic [DATA_WIDTH-1:0] r_s0Data;

    // Data registers only load on an accepted read, which is what holds readdata between pulses.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_s0Valid <= 1'b0;
        r_s0Data  <= '0;
      end else begin
        r_s0Valid <= w_rdEn[p];
        if (w_rdEn[p]) r_s0Data <= r_mem[w_addr[p]];
      end
    end

`ifdef NIOS_OCM_PARITY_EN
    logic [NB-1:0] r_s0Par;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)       r_s0Par <= '0;
      else if (w_rdEn[p]) r_s0Par <= r_par[w_addr[p]];
    end
`endif

    if (READ_LATENCY == 2) begin : g_lat2
      logic                  r_s1Valid;
      logic [DATA_WIDTH-1:0] r_s1Data;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_s1Valid <= 1'b0;
          r_s1Data  <= '0;
        end else begin
          r_s1Valid <= r_s0Valid;
          if (r_s0Valid) r_s1Data <= r_s0Data;
        end
      end
      assign w_rdValid[p] = r_s1Valid;
      assign w_rdData[p]  = r_s1Data;

`ifdef NIOS_OCM_PARITY_EN
      logic [NB-1:0] r_s1Par;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       r_s1Par <= '0;
        else if (r_s0Valid) r_s1Par <= r_s0Par;
      end
      assign w_rdPar[p] = r_s1Par;
`endif
    end else begin : g_lat1
      assign w_rdValid[p] = r_s0Valid;
      assign w_rdData[p]  = r_s0Data;
`ifdef NIOS_OCM_PARITY_EN
      assign w_rdPar[p] = r_s0Par;
`endif
    end

`ifdef NIOS_OCM_PARITY_EN
    assign w_parMiss[p] = w_rdValid[p] & (|(bytePar(w_rdData[p]) ^ w_rdPar[p]));
`endif
  end

  assign s1.readdata      = w_rdData[0];
  assign s2.readdata      = w_rdData[1];
  assign s1.readdatavalid = w_rdValid[0];
  assign s2.readdatavalid = w_rdValid[1];

`ifdef NIOS_OCM_PARITY_EN
  // The flag is visible on the valid cycle itself and latched from the next edge on.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_parErr <= 2'b00;
    else          r_parErr <= r_parErr | w_parMiss;
  end
  assign parity_err = r_parErr | w_parMiss;
`else
  assign parity_err = 2'b00;
`endif

endmodule

// File: tb/tb_nios_onchip_memory_dp.sv
// Directed bench for nios_onchip_memory_dp: one READ_LATENCY=1 and one READ_LATENCY=2 instance driven identically.
// Parity expectations follow NIOS_OCM_PARITY_EN when the bench is compiled with it.
module tb_nios_onchip_memory_dp;

  typedef struct packed {
    logic        cs;
    logic        rd;
    logic        wr;
    logic [10:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } portIn_t;

  typedef struct {
    portIn_t     p1;
    portIn_t     p2;
    logic        rreq;
    logic        e1v;
    logic [31:0] e1d;
    logic        e2v;
    logic [31:0] e2d;
  } vec_t;

`ifdef NIOS_OCM_PARITY_EN
  localparam logic [1:0] INJ_ERR = 2'b10;
`else
  localparam logic [1:0] INJ_ERR = 2'b00;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       reset_req;
  logic       parity_inject;
  logic [1:0] perrL1;
  logic [1:0] perrL2;
  portIn_t    pa;
  portIn_t    pb;
  int         checks   = 0;
  int         failures = 0;
  vec_t       vecs[$];

  always #5 clk = ~clk;

  nios_onchip_memory_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(11)) l1s1 ();
  nios_onchip_memory_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(11)) l1s2 ();
  nios_onchip_memory_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(11)) l2s1 ();
  nios_onchip_memory_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(11)) l2s2 ();

  assign {l1s1.chipselect, l1s1.read, l1s1.write, l1s1.address, l1s1.byteenable, l1s1.writedata} = pa;
  assign {l2s1.chipselect, l2s1.read, l2s1.write, l2s1.address, l2s1.byteenable, l2s1.writedata} = pa;
  assign {l1s2.chipselect, l1s2.read, l1s2.write, l1s2.address, l1s2.byteenable, l1s2.writedata} = pb;
  assign {l2s2.chipselect, l2s2.read, l2s2.write, l2s2.address, l2s2.byteenable, l2s2.writedata} = pb;

  nios_onchip_memory_dp #(
    .DATA_WIDTH(32), .ADDR_WIDTH(11), .READ_LATENCY(1), .INIT_FILE("onchip_mem.hex")
  ) u_dutLat1 (
    .clk(clk), .reset_n(reset_n), .reset_req(reset_req), .parity_inject(parity_inject),
    .parity_err(perrL1), .s1(l1s1), .s2(l1s2)
  );

  nios_onchip_memory_dp #(
    .DATA_WIDTH(32), .ADDR_WIDTH(11), .READ_LATENCY(2), .INIT_FILE("onchip_mem.hex")
  ) u_dutLat2 (
    .clk(clk), .reset_n(reset_n), .reset_req(reset_req), .parity_inject(parity_inject),
    .parity_err(perrL2), .s1(l2s1), .s2(l2s2)
  );

  function automatic portIn_t pIdle();
    return '{cs: 1'b0, rd: 1'b0, wr: 1'b0, addr: 11'h0, be: 4'h0, wd: 32'h0};
  endfunction

  function automatic portIn_t pRd(input logic [10:0] a);
    return '{cs: 1'b1, rd: 1'b1, wr: 1'b0, addr: a, be: 4'h0, wd: 32'h0};
  endfunction

  function automatic portIn_t pWr(input logic [10:0] a, input logic [3:0] be, input logic [31:0] d);
    return '{cs: 1'b1, rd: 1'b0, wr: 1'b1, addr: a, be: be, wd: d};
  endfunction

  function automatic portIn_t pRdWr(input logic [10:0] a, input logic [3:0] be, input logic [31:0] d);
    return '{cs: 1'b1, rd: 1'b1, wr: 1'b1, addr: a, be: be, wd: d};
  endfunction

  function automatic portIn_t pNoCs(input logic [10:0] a);
    return '{cs: 1'b0, rd: 1'b1, wr: 1'b0, addr: a, be: 4'h0, wd: 32'h0};
  endfunction

  task automatic addVec(input portIn_t a, input portIn_t b, input logic rr,
                        input logic e1v, input logic [31:0] e1d,
                        input logic e2v, input logic [31:0] e2d);
    vec_t v;
    v.p1 = a;  v.p2 = b;  v.rreq = rr;
    v.e1v = e1v; v.e1d = e1d; v.e2v = e2v; v.e2d = e2d;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input portIn_t a, input portIn_t b, input logic rr, input logic inj);
    pa = a;
    pb = b;
    reset_req = rr;
    parity_inject = inj;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic actV, input logic [31:0] actD,
                             input logic expV, input logic [31:0] expD);
    checks++;
    if (actV !== expV || actD !== expD) begin
      failures++;
      $display("[TB] FAIL %s: got valid=%0b data=%08h, expected valid=%0b data=%08h",
               name, actV, actD, expV, expD);
    end
  endtask

  task automatic checkErr(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got parity_err=%02b, expected %02b", name, act, exp);
    end
  endtask

  task automatic checkS1(input string tag, input logic ev1, input logic [31:0] ed1,
                         input logic ev2, input logic [31:0] ed2);
    checkOutput({tag, "_lat1"}, l1s1.readdatavalid, l1s1.readdata, ev1, ed1);
    checkOutput({tag, "_lat2"}, l2s1.readdatavalid, l2s1.readdata, ev2, ed2);
  endtask

  initial begin
    logic        prev1V, prev2V;
    logic [31:0] prev1D, prev2D;

    applyStimulus(pIdle(), pIdle(), 1'b0, 1'b0);
    reset_n = 1'b0;
    repeat (3) tick();
    checkOutput("reset_l1s1", l1s1.readdatavalid, l1s1.readdata, 1'b0, 32'h0);
    checkOutput("reset_l1s2", l1s2.readdatavalid, l1s2.readdata, 1'b0, 32'h0);
    checkOutput("reset_l2s1", l2s1.readdatavalid, l2s1.readdata, 1'b0, 32'h0);
    checkOutput("reset_l2s2", l2s2.readdatavalid, l2s2.readdata, 1'b0, 32'h0);
    checkErr("reset_perr", perrL1 | perrL2, 2'b00);
    reset_n = 1'b1;

    // Expectations are for the READ_LATENCY=1 instance; the latency-2 one must lag them by one cycle.
    addVec(pWr(11'h010, 4'hF, 32'hDEADBEEF), pIdle(), 0, 0, 32'h0,        0, 32'h0);
    addVec(pWr(11'h010, 4'h1, 32'h00000055), pIdle(), 0, 0, 32'h0,        0, 32'h0);
    addVec(pIdle(), pRd(11'h010),                     0, 0, 32'h0,        1, 32'hDEADBE55);
    addVec(pIdle(), pIdle(),                          0, 0, 32'h0,        0, 32'hDEADBE55);
    addVec(pWr(11'h7FF, 4'h3, 32'h11111111), pWr(11'h7FF, 4'hE, 32'h22222222),
                                                      0, 0, 32'h0,        0, 32'hDEADBE55);
    addVec(pRd(11'h7FF), pIdle(),                     0, 1, 32'h22221111, 0, 32'hDEADBE55);
    addVec(pWr(11'h020, 4'hF, 32'hA5A5A5A5), pIdle(), 0, 0, 32'h22221111, 0, 32'hDEADBE55);
    addVec(pWr(11'h020, 4'hF, 32'h00000000), pRd(11'h020),
                                                      0, 0, 32'h22221111, 1, 32'hA5A5A5A5);
    addVec(pIdle(), pRd(11'h020),                     0, 0, 32'h22221111, 1, 32'h00000000);
    addVec(pRdWr(11'h030, 4'hF, 32'h12345678), pIdle(), 0, 0, 32'h22221111, 0, 32'h00000000);
    addVec(pIdle(), pRd(11'h030),                     0, 0, 32'h22221111, 1, 32'h12345678);
    addVec(pNoCs(11'h030), pIdle(),                   0, 0, 32'h22221111, 0, 32'h12345678);
    addVec(pWr(11'h040, 4'hF, 32'hCAFEF00D), pIdle(), 0, 0, 32'h22221111, 0, 32'h12345678);
    addVec(pRd(11'h7FF), pIdle(),                     1, 0, 32'h22221111, 0, 32'h12345678);
    addVec(pWr(11'h040, 4'hF, 32'hFFFFFFFF), pIdle(), 1, 0, 32'h22221111, 0, 32'h12345678);
    addVec(pRd(11'h040), pRd(11'h7FF),                0, 1, 32'hCAFEF00D, 1, 32'h22221111);
    addVec(pWr(11'h100, 4'hF, 32'h01010101), pWr(11'h200, 4'hF, 32'h02020202),
                                                      0, 0, 32'hCAFEF00D, 0, 32'h22221111);
    addVec(pRd(11'h200), pRd(11'h100),                0, 1, 32'h02020202, 1, 32'h01010101);
    addVec(pIdle(), pIdle(),                          0, 0, 32'h02020202, 0, 32'h01010101);

    prev1V = 1'b0; prev1D = 32'h0;
    prev2V = 1'b0; prev2D = 32'h0;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].p1, vecs[i].p2, vecs[i].rreq, 1'b0);
      tick();
      checkOutput($sformatf("v%0d_l1s1", i), l1s1.readdatavalid, l1s1.readdata, vecs[i].e1v, vecs[i].e1d);
      checkOutput($sformatf("v%0d_l1s2", i), l1s2.readdatavalid, l1s2.readdata, vecs[i].e2v, vecs[i].e2d);
      checkOutput($sformatf("v%0d_l2s1", i), l2s1.readdatavalid, l2s1.readdata, prev1V, prev1D);
      checkOutput($sformatf("v%0d_l2s2", i), l2s2.readdatavalid, l2s2.readdata, prev2V, prev2D);
      checkErr($sformatf("v%0d_perr", i), perrL1 | perrL2, 2'b00);
      prev1V = vecs[i].e1v; prev1D = vecs[i].e1d;
      prev2V = vecs[i].e2v; prev2D = vecs[i].e2d;
    end

    // A read accepted just before reset_req rises still completes; the blocked one does not.
    applyStimulus(pRd(11'h010), pIdle(), 1'b0, 1'b0);
    tick();
    checkS1("rreq_a", 1'b1, 32'hDEADBE55, 1'b0, 32'h02020202);
    applyStimulus(pRd(11'h010), pIdle(), 1'b1, 1'b0);
    tick();
    checkS1("rreq_b", 1'b0, 32'hDEADBE55, 1'b1, 32'hDEADBE55);
    applyStimulus(pIdle(), pIdle(), 1'b0, 1'b0);
    tick();
    checkS1("rreq_c", 1'b0, 32'hDEADBE55, 1'b0, 32'hDEADBE55);

    for (int a = 0; a < 4; a++) begin
      applyStimulus(pWr(11'(a), 4'hF, 32'h100 + 32'(a)), pIdle(), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(pRd(11'h000), pIdle(), 1'b0, 1'b0);
    tick();
    checkS1("rst_rd0", 1'b1, 32'h100, 1'b0, 32'hDEADBE55);
    applyStimulus(pRd(11'h001), pIdle(), 1'b0, 1'b0);
    tick();
    checkS1("rst_rd1", 1'b1, 32'h101, 1'b1, 32'h100);

    // Reset lands with read 1 still in flight in the latency-2 pipe; reads 2 and 3 arrive during reset.
    reset_n = 1'b0;
    #1;
    checkS1("rst_async", 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus(pRd(11'h002), pIdle(), 1'b0, 1'b0);
    tick();
    applyStimulus(pRd(11'h003), pIdle(), 1'b0, 1'b0);
    tick();
    checkS1("rst_held", 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus(pIdle(), pIdle(), 1'b0, 1'b0);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkS1($sformatf("rst_post%0d", c), 1'b0, 32'h0, 1'b0, 32'h0);
    end
    for (int a = 0; a < 4; a++) begin
      applyStimulus(pRd(11'(a)), pIdle(), 1'b0, 1'b0);
      tick();
      checkS1($sformatf("rst_mem%0d", a), 1'b1, 32'h100 + 32'(a),
              a != 0, (a == 0) ? 32'h0 : 32'h100 + 32'(a - 1));
    end
    applyStimulus(pIdle(), pIdle(), 1'b0, 1'b0);
    tick();
    checkS1("rst_mem_tail", 1'b0, 32'h103, 1'b1, 32'h103);

    applyStimulus(pWr(11'h005, 4'hF, 32'h12345678), pIdle(), 1'b0, 1'b1);
    tick();
    applyStimulus(pIdle(), pRd(11'h005), 1'b0, 1'b0);
    tick();
    checkOutput("par_l1data", l1s2.readdatavalid, l1s2.readdata, 1'b1, 32'h12345678);
    checkErr("par_l1_valid", perrL1, INJ_ERR);
    checkErr("par_l2_early", perrL2, 2'b00);
    applyStimulus(pIdle(), pIdle(), 1'b0, 1'b0);
    tick();
    checkOutput("par_l2data", l2s2.readdatavalid, l2s2.readdata, 1'b1, 32'h12345678);
    checkErr("par_l1_sticky", perrL1, INJ_ERR);
    checkErr("par_l2_valid", perrL2, INJ_ERR);
    repeat (2) tick();
    checkErr("par_l1_hold", perrL1, INJ_ERR);
    checkErr("par_l2_hold", perrL2, INJ_ERR);
    reset_n = 1'b0;
    #1;
    checkErr("par_clear", perrL1 | perrL2, 2'b00);
    tick();
    reset_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nios_onchip_memory_dp.md
NIOS_ONCHIP_MEMORY_DP -- requirements
Module: nios_onchip_memory_dp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; multiple of 8, 8..128.
REQ-002 SHALL have parameter ADDR_WIDTH, default 11, word-address width; depth = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter READ_LATENCY, default 1, read latency in cycles; legal values 1 or 2.
REQ-004 SHALL have parameter INIT_FILE, default "onchip_mem.hex", initial memory contents.
REQ-005 SHALL have port clk  in  1  single clock for all logic; rising edge.
REQ-006 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port reset_req  in  1  high blocks acceptance of new accesses on both ports.
REQ-008 SHALL have, for p in {s1,s2}, port p_address  in  ADDR_WIDTH  word address.
REQ-009 SHALL have, per port, p_chipselect, p_read, p_write  in  1 each  Avalon-MM slave controls.
REQ-010 SHALL have, per port, p_byteenable  in  DATA_WIDTH/8  byte lane enables.
REQ-011 SHALL have, per port, p_writedata  in  DATA_WIDTH  write data.
REQ-012 SHALL have, per port, p_readdata  out  DATA_WIDTH  read data.
REQ-013 SHALL have, per port, p_readdatavalid  out  1  one-cycle pulse qualifying p_readdata.
REQ-014 SHALL have port parity_err  out  2  sticky error flags, bit0 = s1, bit1 = s2.
REQ-015 SHALL have port parity_inject  in  1  test hook: writes store inverted parity.

Function
REQ-016 SHALL implement a true dual-port RAM of 2**ADDR_WIDTH x DATA_WIDTH; no waitrequest, one access per port per cycle.
REQ-017 SHALL accept an access on port p at a clk edge when p_chipselect & (p_read | p_write) & ~reset_req.
REQ-018 SHALL, on an accepted write, update only byte lanes with byteenable=1 at that edge; other lanes unchanged.
REQ-019 SHALL treat p_read & p_write together as a write only: no read, no readdatavalid.
REQ-020 SHALL present read data with p_readdatavalid=1 exactly READ_LATENCY cycles after the accepting edge; back-to-back reads give back-to-back valid pulses, in order.
REQ-021 SHALL hold p_readdata at its last valid value while p_readdatavalid=0.
REQ-022 SHALL return old (pre-write) data for a read of an address written in the same cycle, same port or other port.
REQ-023 SHALL, when both ports write the same address in one cycle, take s1 data on lanes s1 enables and s2 data on lanes only s2 enables.
REQ-024 SHALL let reads accepted before reset_req rises complete normally.
REQ-025 SHALL ignore byteenable on reads (full word returned).

Reset
REQ-026 SHALL, while reset_n=0, force p_readdata=0, p_readdatavalid=0, parity_err=2'b00 asynchronously.
REQ-027 SHALL discard in-flight reads on reset; none produce readdatavalid after release.
REQ-028 SHALL NOT alter memory contents on reset; accesses resume on the first edge with reset_n=1.

Configuration
REQ-029 SHALL, with macro NIOS_OCM_PARITY_EN defined, store one even-parity bit per byte, recompute parity on every read, and set parity_err[p] on the readdatavalid cycle of any mismatching read; sticky until reset_n.
REQ-030 SHALL, with NIOS_OCM_PARITY_EN defined, store inverted parity for enabled lanes of writes accepted while parity_inject=1.
REQ-031 SHALL, without NIOS_OCM_PARITY_EN, omit parity storage, tie parity_err to 0 and ignore parity_inject.

Verification
REQ-032 SHALL cover: s1 write 0xDEADBEEF @0x010 be=4'b1111, then s1 write 0x00000055 @0x010 be=4'b0001, then s2 read 0x010 -> s2_readdata=0xDEADBE55, valid READ_LATENCY cycles after read.
REQ-033 SHALL cover: same cycle s1 write 0x11111111 be=4'b0011 and s2 write 0x22222222 be=4'b1110 @0x7FF, then read -> 0x22221111.
REQ-034 SHALL cover: @0x020 holds 0xA5A5A5A5; same cycle s1 write 0x0 @0x020 and s2 read 0x020 -> s2_readdata=0xA5A5A5A5; next s2 read -> 0x00000000.
REQ-035 SHALL cover: READ_LATENCY=2, four back-to-back s1 reads @0..3, reset_n pulsed low after the second -> readdata=0, no valid pulses after release, memory @0..3 unchanged.
REQ-036 SHALL cover: reset_req=1 with s1 read asserted -> no readdatavalid; a read accepted the prior cycle still returns valid data.
REQ-037 SHALL cover (NIOS_OCM_PARITY_EN): write 0x12345678 @0x005 with parity_inject=1, s2 read 0x005 -> parity_err=2'b10 on the valid cycle, held until reset_n=0; without macro parity_err stays 2'b00.
